// File: rtl/cv32e40p_int_controller_prio_if.sv
// Bundle of interrupt lines, line configuration and controller handshake for cv32e40p_int_controller_prio.
// master = core/testbench side, slave = interrupt controller.
interface cv32e40p_int_controller_prio_if #(
  parameter int NUM_IRQ = 32,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = $clog2(NUM_IRQ)
);
  logic [NUM_IRQ-1:0] irq_i;
  logic               cfg_we_i;
  logic [ID_W-1:0]    cfg_idx_i;
  logic [PRIO_W-1:0]  cfg_prio_i;
  logic               cfg_ie_i;
  logic               cfg_edge_i;
  logic               m_ie_i;
  logic [PRIO_W-1:0]  threshold_i;
  logic               irq_ack_i;
  logic               irq_req_ctrl_o;
  logic [ID_W-1:0]    irq_id_ctrl_o;
  logic [PRIO_W-1:0]  irq_level_o;
  logic               irq_wu_ctrl_o;
  logic [NUM_IRQ-1:0] mip_o;

  modport master (
    output irq_i, cfg_we_i, cfg_idx_i, cfg_prio_i, cfg_ie_i, cfg_edge_i,
           m_ie_i, threshold_i, irq_ack_i,
    input  irq_req_ctrl_o, irq_id_ctrl_o, irq_level_o, irq_wu_ctrl_o, mip_o
  );

  modport slave (
    input  irq_i, cfg_we_i, cfg_idx_i, cfg_prio_i, cfg_ie_i, cfg_edge_i,
           m_ie_i, threshold_i, irq_ack_i,
    output irq_req_ctrl_o, irq_id_ctrl_o, irq_level_o, irq_wu_ctrl_o, mip_o
  );
endinterface

// File: rtl/cv32e40p_int_controller_prio.sv
// Prioritised interrupt controller: per-line priority/enable, max-priority arbitration, registered request.
// Define CV32E40P_IRQ_EDGE_EN to build rising-edge lines with pending latches; otherwise all lines are level.
module cv32e40p_int_controller_prio #(
  parameter int          NUM_IRQ  = 32,
  parameter int          PRIO_W   = 3,
  parameter logic [31:0] IRQ_MASK = 32'hFFFF_0888,
  parameter int          ID_W     = $clog2(NUM_IRQ)
) (
  input logic                           clk,
  input logic                           rst_n,
  cv32e40p_int_controller_prio_if.slave bus
);

  localparam logic [NUM_IRQ-1:0] LINE_MASK = IRQ_MASK[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] ie_q;
  logic [PRIO_W-1:0]  prio_q [NUM_IRQ];
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] cand;
  logic               cfg_ok;
  logic               ack_valid;
  logic [PRIO_W-1:0]  win_prio;
  logic [ID_W-1:0]    win_id;
  logic               req_q;
  logic [ID_W-1:0]    id_q;
  logic [PRIO_W-1:0]  level_q;

  // Masked or out-of-range lines never get written, so their config stays zero.
  assign cfg_ok    = bus.cfg_we_i && (int'(bus.cfg_idx_i) < NUM_IRQ) && IRQ_MASK[bus.cfg_idx_i];
  assign ack_valid = bus.irq_ack_i && req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q <= '0;
      for (int i = 0; i < NUM_IRQ; i++) prio_q[i] <= '0;
    end else if (cfg_ok) begin
      prio_q[bus.cfg_idx_i] <= bus.cfg_prio_i;
      ie_q[bus.cfg_idx_i]   <= bus.cfg_ie_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= '0;
    else        irq_q <= bus.irq_i & LINE_MASK;
  end

`ifdef CV32E40P_IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] edge_q;
  logic [NUM_IRQ-1:0] irq_q_d;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] edge_set;
  logic [NUM_IRQ-1:0] lvl_clr;

  assign edge_set = edge_q & irq_q & ~irq_q_d;

  always_comb begin
    ack_clr = '0;
    lvl_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_clr[i] = ack_valid && edge_q[i] && (id_q == ID_W'(i));
      lvl_clr[i] = cfg_ok && !bus.cfg_edge_i && (bus.cfg_idx_i == ID_W'(i));
    end
  end

  // A fresh edge beats the ack; leaving edge mode drops whatever was latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q  <= '0;
      irq_q_d <= '0;
      pend_q  <= '0;
    end else begin
      irq_q_d <= irq_q;
      pend_q  <= (edge_set | (pend_q & ~ack_clr)) & ~lvl_clr;
      if (cfg_ok) edge_q[bus.cfg_idx_i] <= bus.cfg_edge_i;
    end
  end

  assign pending = (edge_q & (pend_q | edge_set)) | (~edge_q & irq_q);
`else
  logic unused_edge_cfg;

  assign unused_edge_cfg = bus.cfg_edge_i ^ ack_valid;
  assign ack_clr         = '0;
  assign pending         = irq_q;
`endif

  // The line being acked is left out so the next cycle cannot re-present a stale request.
  assign cand = pending & ie_q & LINE_MASK & ~ack_clr;

  always_comb begin
    win_prio = '0;
    win_id   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cand[i] && (prio_q[i] != '0) && (prio_q[i] >= win_prio)) begin
        win_prio = prio_q[i];
        win_id   = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      id_q    <= '0;
      level_q <= '0;
    end else begin
      req_q   <= bus.m_ie_i && (win_prio > bus.threshold_i);
      id_q    <= win_id;
      level_q <= win_prio;
    end
  end

  assign bus.irq_req_ctrl_o = req_q;
  assign bus.irq_id_ctrl_o  = id_q;
  assign bus.irq_level_o    = level_q;
  assign bus.irq_wu_ctrl_o  = |(bus.irq_i & LINE_MASK & ie_q);
  assign bus.mip_o          = pending;

endmodule
